paddle_mouse_emu: RTL
=====================

Name: paddle_mouse_emu

Overview:
- Sits between hps_io and the A2601top console core.
- Converts PS/2 mouse motion packets into saturating 8-bit paddle positions.
- Arbitrates between mouse-emulated paddles and real analog joystick paddles.
- Drives paddle_0/paddle_1 and the P1 fire/paddle-button lines (p_a/p_b) of the core.

Parameters:
- DELTA_LIMIT, 10: maximum magnitude of the per-packet halved delta added to an accumulator.
- ACC_MIN, -128: lower saturation bound of each accumulator (signed).
- ACC_MAX, 127: upper saturation bound of each accumulator (signed).

Ports:
- clk_sys  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2_mouse  in  25  hps_io mouse packet.
  - [24] toggle strobe, [23:16] dy, [15:8] dx.
  - [5] dy sign, [4] dx sign, [1:0] right/left buttons.
- joya  in  16  analog stick: [7:0] X, [15:8] Y, signed.
- joy  in  8  digital joystick bits [7:0] of player 1.
- recenter  in  1  single-cycle pulse: zero both accumulators, mode unchanged.
- paddle_x  out  8  paddle 0 position (two's complement).
- paddle_y  out  8  paddle 1 position (two's complement).
- joy_out  out  8  joystick bits with paddle buttons substituted in mouse mode.
- mouse_active  out  1  1 = mouse mode, 0 = analog mode.
- update  out  1  one-cycle pulse when paddle_x/paddle_y change due to a mouse packet.

Behaviour:
- Reset values: acc_x = acc_y = 0 (9-bit signed), mouse_active = 0, update = 0, paddle_x = paddle_y = 0, joy_out = 0.
- Strobe arm: on the first clock after reset deassertion, capture old_stb <= ps2_mouse[24] with no event; armed flag set.
  - Afterwards, event = armed & (ps2_mouse[24] != old_stb); old_stb updated every cycle.
  - Reset mid-packet therefore never produces a spurious event.
- Two-state FSM on mouse_active:
  - ANALOG -> MOUSE on event.
  - MOUSE -> ANALOG when joya != 0.
  - If both happen in the same cycle, the analog condition wins: state ANALOG, accumulators cleared, event ignored.
- Delta, 9-bit signed:
  - mdx = {ps2_mouse[4], ps2_mouse[4], ps2_mouse[15:9]}, i.e. dx arithmetically halved.
  - mdy is built the same way from [5] and [23:17].
  - Clamp each to [-DELTA_LIMIT, +DELTA_LIMIT].
- Accumulate: on event, nx = acc_x + clamped mdx, computed in 10 bits (no overflow); saturate to [ACC_MIN, ACC_MAX]. Y axis identical and independent.
- Transition into analog mode (joya != 0 in any state) clears both accumulators in that cycle.
- recenter: clears both accumulators. If it coincides with an event, clear wins for that cycle and update stays 0.
- Output stage, registered, 1-cycle latency from the registered state:
  - paddle_x = mouse_active ? acc_x[7:0] : joya[7:0]
  - paddle_y = mouse_active ? acc_y[7:0] : joya[15:8]
  - joy_out = mouse_active ? {joy[7], ps2_mouse[1:0], joy[4:0]} : joy
  - Mouse left button maps to bit 5, right button to bit 6.
- update: asserted with the output register load that first shows new accumulator values after an applied event. Asserted even if saturation left the values unchanged.
- No handshake back to hps_io. Events closer than 2 cycles apart cannot occur because of the strobe protocol; no queuing is needed.

Test Plan:
- Reset, then hold ps2_mouse[24]=1 constant -> no event; mouse_active=0; paddle_x tracks joya[7:0]=8'h35 one cycle later.
- Toggle strobe with dx=8'h08, sign=0 -> mdx=+4; mouse_active=1; paddle_x=8'h04 two cycles after the toggle; update pulses once.
- Twenty toggles with dx=8'h7F (mdx=63 clamped to 10) -> acc_x saturates at 127; paddle_x=8'h7F; further packets keep 8'h7F.
- Negative packets with dx=8'h80, sign=1 (mdx=-64 clamped to -10), repeated 30 times -> paddle_x=8'h80 (-128) and holds.
- In mouse mode, set joya=16'h0100 in the same cycle as a strobe toggle -> mouse_active=0, accumulators 0, paddle_y=8'h01, update=0.
- In mouse mode with ps2_mouse[1:0]=2'b01 and joy=8'h10 -> joy_out=8'h30; pulse recenter -> paddle_x=paddle_y=0 while mouse_active stays 1.

Source files
------------

// File: rtl/paddle_mouse_emu_if.sv
// Paddle emulator signal bundle between hps_io/joystick sources and the console core.
// The master side drives mouse/joystick inputs; the slave side produces paddle outputs.
interface paddle_mouse_emu_if;
    logic [24:0] ps2_mouse;
    logic [15:0] joya;
    logic [7:0]  joy;
    logic        recenter;
    logic [7:0]  paddle_x;
    logic [7:0]  paddle_y;
    logic [7:0]  joy_out;
    logic        mouse_active;
    logic        update;

    modport master (
        output ps2_mouse, joya, joy, recenter,
        input  paddle_x, paddle_y, joy_out, mouse_active, update
    );

    modport slave (
        input  ps2_mouse, joya, joy, recenter,
        output paddle_x, paddle_y, joy_out, mouse_active, update
    );
endinterface

// File: rtl/paddle_mouse_emu.sv
// Mouse-to-paddle emulation with analog joystick arbitration.
// Mouse packets move saturating 8-bit paddle positions; analog input takes over when non-zero.
module paddle_mouse_emu #(
    parameter int DELTA_LIMIT = 10,
    parameter int ACC_MIN     = -128,
    parameter int ACC_MAX     = 127
) (
    input logic               clk_sys,
    input logic               reset,
    paddle_mouse_emu_if.slave bus
);

    typedef enum logic {ANALOG, MOUSE} mode_t;

    localparam logic signed [8:0] LIM = 9'(DELTA_LIMIT);
    localparam logic signed [9:0] HI  = 10'(ACC_MAX);
    localparam logic signed [9:0] LO  = 10'(ACC_MIN);

    mode_t             mode;
    logic              armed;
    logic              old_stb;
    logic              applied;
    logic signed [8:0] acc_x;
    logic signed [8:0] acc_y;

    logic              evt;
    logic              analog_hit;
    logic signed [8:0] raw_x, raw_y;
    logic signed [8:0] mdx, mdy;
    logic signed [9:0] sum_x, sum_y;
    logic signed [8:0] nx, ny;

    assign evt        = armed && (bus.ps2_mouse[24] != old_stb);
    assign analog_hit = (bus.joya != 16'h0000);

    // Halve and clamp the packet deltas, then add with saturation.
    always_comb begin
        raw_x = {bus.ps2_mouse[4], bus.ps2_mouse[4], bus.ps2_mouse[15:9]};
        raw_y = {bus.ps2_mouse[5], bus.ps2_mouse[5], bus.ps2_mouse[23:17]};
        mdx   = raw_x;
        mdy   = raw_y;
        if (raw_x > LIM)
            mdx = LIM;
        else if (raw_x < -LIM)
            mdx = -LIM;
        if (raw_y > LIM)
            mdy = LIM;
        else if (raw_y < -LIM)
            mdy = -LIM;
        sum_x = {acc_x[8], acc_x} + {mdx[8], mdx};
        sum_y = {acc_y[8], acc_y} + {mdy[8], mdy};
        nx    = sum_x[8:0];
        ny    = sum_y[8:0];
        if (sum_x > HI)
            nx = HI[8:0];
        else if (sum_x < LO)
            nx = LO[8:0];
        if (sum_y > HI)
            ny = HI[8:0];
        else if (sum_y < LO)
            ny = LO[8:0];
    end

    // Strobe edge detection, mode FSM and accumulators; analog input beats everything.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mode    <= ANALOG;
            armed   <= 1'b0;
            old_stb <= 1'b0;
            applied <= 1'b0;
            acc_x   <= '0;
            acc_y   <= '0;
        end else begin
            old_stb <= bus.ps2_mouse[24];
            armed   <= 1'b1;
            applied <= 1'b0;
            if (analog_hit) begin
                mode  <= ANALOG;
                acc_x <= '0;
                acc_y <= '0;
            end else begin
                if (evt)
                    mode <= MOUSE;
                if (bus.recenter) begin
                    acc_x <= '0;
                    acc_y <= '0;
                end else if (evt) begin
                    acc_x   <= nx;
                    acc_y   <= ny;
                    applied <= 1'b1;
                end
            end
        end
    end

    assign bus.mouse_active = (mode == MOUSE);

    // Registered output stage selecting mouse or analog sources.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bus.paddle_x <= '0;
            bus.paddle_y <= '0;
            bus.joy_out  <= '0;
            bus.update   <= 1'b0;
        end else begin
            bus.update <= applied;
            if (mode == MOUSE) begin
                bus.paddle_x <= acc_x[7:0];
                bus.paddle_y <= acc_y[7:0];
                bus.joy_out  <= {bus.joy[7], bus.ps2_mouse[1:0], bus.joy[4:0]};
            end else begin
                bus.paddle_x <= bus.joya[7:0];
                bus.paddle_y <= bus.joya[15:8];
                bus.joy_out  <= bus.joy;
            end
        end
    end

endmodule
